atm_pager_rdback: RTL
=====================

Name: atm_pager_rdback

Overview:
- Read-back responder for the ATM pager ports: answers Z80 IN from port xxBE with pager state, the read side of the xxF7 write ports.
- Takes the read-back buses of all four window pagers (pages for both pent1m_ROM maps, dos_7ffd, ramnrom, wrdisables).
- Snapshots the addressed byte at the start of the I/O read cycle and holds it stable until the cycle ends.
- Sits between the pager instances and the Z80 data-bus read mux in the ports block.

Parameters:
PORT_LO, 8'hBE, low address byte decoded as the read-back port
NWIN, 4, number of pager windows served (fixed 4; other values unsupported)

Ports:
fclk  in  1  system clock (28 MHz)
rst_n  in  1  reset, asynchronous, active-low
zpos  in  1  Z80 clock positive-edge strobe (1 fclk wide)
zneg  in  1  Z80 clock negative-edge strobe (1 fclk wide)
za  in  16  Z80 address bus
iorq_n  in  1  Z80 IORQ
rd_n  in  1  Z80 RD
m1_n  in  1  Z80 M1 (low with IORQ = interrupt ack, never a port read)
port_en  in  1  read-back port enable from config; 0 = block never responds
pages0  in  32  per-window pages for map 0, window N at [8N+7:8N]
pages1  in  32  per-window pages for map 1, same packing
dos7ffd  in  8  window N bits at [2N+1:2N], bit 2N = map 0
ramnrom  in  8  same packing
wrdisables  in  8  same packing
rd_data  out  8  captured read-back byte
rd_valid  out  1  rd_data valid; drives read-mux select
rd_done  out  1  one-fclk pulse at end of each served read

Behaviour:
- Reset: state IDLE, rd_data=8'hFF, rd_valid=0, rd_done=0, iorq_n_reg=1. Asynchronous. Reset mid-cycle returns to IDLE. The same Z80 cycle is not re-served after release unless iorq_n is first seen high.
- iorq_n_reg: registered from iorq_n on each zneg. A cycle start is iorq_n_reg=1 with iorq_n=0 on that zneg.
- Hit condition, evaluated on zneg only: cycle start, !rd_n, m1_n, za[7:0]==PORT_LO, port_en.
- Byte select by za[15:8] at the hit:
  - 0x00-0x03: pages0 byte of window za[9:8]
  - 0x04-0x07: pages1 byte of window za[9:8]
  - 0x08: packed ramnrom as {w3m1,w3m0,w2m1,w2m0,w1m1,w1m0,w0m1,w0m0}, i.e. ramnrom[7:0] as is
  - 0x09: dos7ffd, same packing
  - 0x0A: wrdisables, same packing
  - any other value: 8'hFF
- States:
  - IDLE: on hit, rd_data <= selected byte and go to HOLD. rd_valid rises on the same fclk edge as the capture, so latency from the hit zneg to valid is 1 fclk.
  - HOLD: rd_data and rd_valid frozen; input buses may change freely. Leave on any fclk where iorq_n==1 (not gated by zpos/zneg). On leaving go to IDLE, clear rd_valid and pulse rd_done for 1 fclk. rd_data keeps its last value.
- port_en falling during HOLD does not abort the cycle; it only blocks new hits.
- A write cycle (wr) to PORT_LO never hits. An IORQ+M1 cycle never hits.
- A hit is impossible in HOLD, because a start needs iorq_n_reg=1.
- Exactly one rd_done per hit.

Decomposition:
- Shared package/include: PORT_LO default, selector codes SEL_PAGE0_BASE=8'h00, SEL_PAGE1_BASE=8'h04, SEL_RAMNROM=8'h08, SEL_DOS7FFD=8'h09, SEL_WRDIS=8'h0A, default byte 8'hFF, and the state encoding (IDLE/HOLD).
- One natural sub-module: atm_rdback_sel, a purely combinational byte selector from za[15:8] and the input buses. The FSM, edge detect and capture register stay in the top module.

Test Plan:
- pages0=32'h44332211, IN from 0x02BE with port_en=1 -> rd_data=8'h33 one fclk after the hit zneg; rd_valid high until iorq_n rises; one rd_done pulse.
- ramnrom=8'hA5, IN from 0x08BE; change ramnrom to 8'h00 mid-cycle -> rd_data stays 8'hA5 for the whole HOLD.
- IN from 0x0BBE -> rd_data=8'hFF. OUT to 0x02BE -> rd_valid stays 0. IORQ+M1 cycle with za=0x00BE -> no response.
- port_en=0, IN from 0x05BE -> no rd_valid and no rd_done. Set port_en=1, next IN from 0x05BE -> pages1 window 1 byte returned.
- Assert rst_n low during HOLD -> rd_valid=0 and rd_data=8'hFF immediately; after release with iorq_n still low -> no capture until a new cycle start.
- Back-to-back INs from 0x00BE then 0x09BE (iorq_n high for 1 zneg between) -> two rd_done pulses with correct bytes.

Source files
------------

// File: rtl/atm_pager_rdback_pkg.sv
// Shared constants and types for the ATM pager read-back responder.
package atm_pager_rdback_pkg;

    // Low address byte of the read-back port.
    localparam logic [7:0] PORT_LO_DEF    = 8'hBE;

    // Values of za[15:8] that select the returned byte.
    localparam logic [7:0] SEL_PAGE0_BASE = 8'h00;
    localparam logic [7:0] SEL_PAGE1_BASE = 8'h04;
    localparam logic [7:0] SEL_RAMNROM    = 8'h08;
    localparam logic [7:0] SEL_DOS7FFD    = 8'h09;
    localparam logic [7:0] SEL_WRDIS      = 8'h0A;

    // Byte returned for unused selectors and held while nothing was captured.
    localparam logic [7:0] DEFAULT_BYTE   = 8'hFF;

    // Responder state: waiting for a hit, or holding a captured byte.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rdback_state_e;

endpackage

// File: rtl/atm_rdback_sel.sv
// Combinational byte selector: picks the read-back byte addressed by za[15:8].
module atm_rdback_sel
    import atm_pager_rdback_pkg::*;
#(
    parameter int NWIN = 4
) (
    input  logic [7:0]        sel_i,
    input  logic [8*NWIN-1:0] pages0_i,
    input  logic [8*NWIN-1:0] pages1_i,
    input  logic [2*NWIN-1:0] dos7ffd_i,
    input  logic [2*NWIN-1:0] ramnrom_i,
    input  logic [2*NWIN-1:0] wrdisables_i,
    output logic [7:0]        byte_o
);

    localparam int WIN_W = $clog2(NWIN);

    logic [WIN_W-1:0] win_s;
    logic [7:0]       byte_s;

    // The low selector bits name the window inside a page group.
    assign win_s = sel_i[WIN_W-1:0];

    // Decode the selector: page groups share one window index, the packed
    // two-bit-per-window buses are returned as they come, anything else reads 0xFF.
    always_comb begin
        byte_s = DEFAULT_BYTE;
        if (sel_i[7:WIN_W] == SEL_PAGE0_BASE[7:WIN_W]) begin
            byte_s = pages0_i[{win_s, 3'b000} +: 8];
        end else if (sel_i[7:WIN_W] == SEL_PAGE1_BASE[7:WIN_W]) begin
            byte_s = pages1_i[{win_s, 3'b000} +: 8];
        end else begin
            case (sel_i)
                SEL_RAMNROM: byte_s = ramnrom_i;
                SEL_DOS7FFD: byte_s = dos7ffd_i;
                SEL_WRDIS:   byte_s = wrdisables_i;
                default:     byte_s = DEFAULT_BYTE;
            endcase
        end
    end

    assign byte_o = byte_s;

endmodule

// File: rtl/atm_pager_rdback.sv
// Read-back responder for the ATM pager ports: answers Z80 IN from xxBE with
// a pager-state byte captured at the start of the I/O cycle and held until
// IORQ goes away.
module atm_pager_rdback
    import atm_pager_rdback_pkg::*;
#(
    parameter logic [7:0] PORT_LO = PORT_LO_DEF,
    parameter int         NWIN    = 4
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              zpos,
    input  logic              zneg,
    input  logic [15:0]       za,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              m1_n,
    input  logic              port_en,
    input  logic [8*NWIN-1:0] pages0,
    input  logic [8*NWIN-1:0] pages1,
    input  logic [2*NWIN-1:0] dos7ffd,
    input  logic [2*NWIN-1:0] ramnrom,
    input  logic [2*NWIN-1:0] wrdisables,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              rd_done
);

    rdback_state_e state_q, state_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_done_q, rd_done_d;
    logic          iorq_n_reg_q, iorq_n_reg_d;
    // Cleared by reset; set once IORQ is seen idle, so a cycle already in
    // progress at reset release is never served.
    logic          armed_q, armed_d;

    logic          cycle_start_s;
    logic          hit_s;
    logic [7:0]    sel_byte_s;
    logic          unused_zpos_s;

    // Capture timing is purely zneg based; the positive strobe is not needed.
    assign unused_zpos_s = zpos;

    atm_rdback_sel #(
        .NWIN (NWIN)
    ) u_sel (
        .sel_i        (za[15:8]),
        .pages0_i     (pages0),
        .pages1_i     (pages1),
        .dos7ffd_i    (dos7ffd),
        .ramnrom_i    (ramnrom),
        .wrdisables_i (wrdisables),
        .byte_o       (sel_byte_s)
    );

    // A cycle starts on the zneg where IORQ is first seen low.
    assign cycle_start_s = zneg & iorq_n_reg_q & ~iorq_n;

    // Only a plain port read (not interrupt ack, not a write) to our port hits.
    assign hit_s = cycle_start_s & ~rd_n & m1_n & (za[7:0] == PORT_LO) &
                   port_en & armed_q & (state_q == ST_IDLE);

    // State and capture registers, all cleared asynchronously.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_data_q    <= DEFAULT_BYTE;
            rd_valid_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            iorq_n_reg_q <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_done_q    <= rd_done_d;
            iorq_n_reg_q <= iorq_n_reg_d;
            armed_q      <= armed_d;
        end
    end

    // Next state: capture on a hit, release as soon as IORQ is deasserted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (iorq_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (zneg) begin
            iorq_n_reg_d = iorq_n;
        end else begin
            iorq_n_reg_d = iorq_n_reg_q;
        end

        if (iorq_n) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Output next-values: data is latched only on a hit and kept afterwards,
    // valid tracks HOLD, done marks the HOLD-to-IDLE transition.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        if (hit_s) begin
            rd_data_d = sel_byte_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = (state_d == ST_HOLD);
        rd_done_d  = (state_q == ST_HOLD) && (state_d == ST_IDLE);
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_done  = rd_done_q;

endmodule
